i2c_master_read_bit: RTL and testbench

Bit-level I2C master receive engine: generates one SCL pulse with SDA released and samples the bit driven by the slave, either a data bit or the ACK/NACK slot. It is the receive-direction companion of the master write-bit engine and sits beneath the byte-level master controller, which sequences it with the same go/finish handshake. It supports slave clock stretching and flags illegal SDA transitions while SCL is high.

---
 rtl/i2c_master_read_bit.sv | 161 ++++++++++++++++
 tb/tb_i2c_master_read_bit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_read_bit.sv
// Bit-level I2C master receive engine: clocks one SCL pulse with SDA released,
// samples the slave's bit (data or ACK slot), honours clock stretching and
// flags SDA movement while SCL is high.
module i2c_master_read_bit #(
  parameter int unsigned QUARTER = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [1:0] command,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl,
  output logic       finish,
  output logic       data_bit,
  output logic       ack_ok,
  output logic       bus_error
);

  localparam int unsigned CNT_W = (QUARTER > 2) ? $clog2(QUARTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER - 1);
  localparam logic [1:0] CMD_ACK = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW1  = 3'd1,
    LOW2  = 3'd2,
    HIGH1 = 3'd3,
    HIGH2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       scl_sync_q, scl_sync_d;
  logic [1:0]       sda_sync_q, sda_sync_d;
  logic             scl_q, scl_d;
  logic             finish_q, finish_d;
  logic             data_bit_q, data_bit_d;
  logic             ack_ok_q, ack_ok_d;
  logic             bus_error_q, bus_error_d;

  logic scl_hi;
  logic sda_s;
  logic cnt_last;

  assign scl_hi   = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign cnt_last = (cnt_q == CNT_LAST);

  // Two-flop synchronizers for the bus lines
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
  end

  // State and datapath registers; reset releases SCL at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_q       <= 1'b1;
      finish_q    <= 1'b0;
      data_bit_q  <= 1'b0;
      ack_ok_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_q       <= scl_d;
      finish_q    <= finish_d;
      data_bit_q  <= data_bit_d;
      ack_ok_q    <= ack_ok_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next-state: quarter-period phases, HIGH1 waits for SCL seen high
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = command[1] ? DONE : LOW1;
      LOW1:    if (cnt_last) state_d = LOW2;
      LOW2:    if (cnt_last) state_d = HIGH1;
      HIGH1:   if (scl_hi && cnt_last) state_d = HIGH2;
      HIGH2:   if (cnt_last) state_d = DONE;
      DONE:    if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs, quarter counter, sampling and SDA-stability monitoring
  always_comb begin
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    scl_d       = scl_q;
    finish_d    = finish_q;
    data_bit_d  = data_bit_q;
    ack_ok_d    = ack_ok_q;
    bus_error_d = bus_error_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go) begin
          cmd_d       = command;
          data_bit_d  = 1'b0;
          ack_ok_d    = 1'b0;
          bus_error_d = command[1];
          if (command[1]) finish_d = 1'b1;
          else            scl_d    = 1'b0;
        end
      end
      LOW1, LOW2: begin
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (state_q == LOW2 && cnt_last) scl_d = 1'b1;
      end
      HIGH1: begin
        if (!scl_hi) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          cnt_d      = '0;
          data_bit_d = sda_s;
          ack_ok_d   = (cmd_q == CMD_ACK) && !sda_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH2: begin
        if (sda_s != data_bit_q) bus_error_d = 1'b1;
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
          scl_d    = 1'b0;
          finish_d = 1'b1;
        end
      end
      DONE: begin
        if (!go) begin
          scl_d    = 1'b1;
          finish_d = 1'b0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign scl       = scl_q;
  assign finish    = finish_q;
  assign data_bit  = data_bit_q;
  assign ack_ok    = ack_ok_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_i2c_master_read_bit.sv
// Scoreboard bench for i2c_master_read_bit: the driver pushes the expected
// outcome of each bit, a monitor pops and compares at every finish rise.
module tb_i2c_master_read_bit;

  localparam int Q = 2;

  logic       clk;
  logic       rst;
  logic       go;
  logic [1:0] command;
  logic       scl_in;
  logic       sda_in;
  logic       scl;
  logic       finish;
  logic       data_bit;
  logic       ack_ok;
  logic       bus_error;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  // Edge indices are counted as "sampled just after edge N"
  typedef struct {
    int   fin;
    int   fall;
    int   rise;
    bit   res;
    logic db;
    logic ack;
    logic err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  i2c_master_read_bit #(.QUARTER(Q)) dut (
    .clock     (clk),
    .reset     (rst),
    .go        (go),
    .command   (command),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (scl),
    .finish    (finish),
    .data_bit  (data_bit),
    .ack_ok    (ack_ok),
    .bus_error (bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, $signed(act), $signed(req), $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int t);
    while (ecnt < t) step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_scl"},       32'(scl),       32'd1);
    chk({tag, "_finish"},    32'(finish),    32'd0);
    chk({tag, "_data_bit"},  32'(data_bit),  32'd0);
    chk({tag, "_ack_ok"},    32'(ack_ok),    32'd0);
    chk({tag, "_bus_error"}, 32'(bus_error), 32'd0);
  endtask

  // Monitor: tracks SCL edges and checks results when finish rises
  int   fall_e   = -1;
  int   rise_e   = -1;
  logic prev_fin = 1'b0;
  logic prev_scl = 1'b1;

  always @(posedge clk) begin
    ecnt = ecnt + 1;
    #1;
    if (rst) begin
      fall_e = -1;
      rise_e = -1;
    end else begin
      if (prev_scl && !scl && fall_e < 0) fall_e = ecnt;
      else if (!prev_scl && scl && fall_e >= 0 && rise_e < 0) rise_e = ecnt;
      if (finish && !prev_fin) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_finish actual=1 required=0 t=%0t", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("finish_edge", 32'(ecnt),      32'(mon_e.fin));
          chk("data_bit",    32'(data_bit),  32'(mon_e.db));
          chk("ack_ok",      32'(ack_ok),    32'(mon_e.ack));
          chk("bus_error",   32'(bus_error), 32'(mon_e.err));
          chk("scl_at_fin",  32'(scl),       mon_e.res ? 32'd1 : 32'd0);
          chk("scl_fall",    32'(fall_e),    32'(mon_e.fall));
          chk("scl_rise",    32'(rise_e),    32'(mon_e.rise));
        end
        fall_e = -1;
        rise_e = -1;
      end
    end
    prev_fin = finish;
    prev_scl = scl;
  end

  // One bit transfer: s = stretch cycles after release, tog = SDA moves in SCL-high
  task automatic run_bit(input logic [1:0] cmd, input logic sda, input int s,
                         input bit tog, input bit drop_early, input int hold,
                         input bit rst_done);
    int   a;
    int   ext;
    int   guard;
    exp_t e;
    command = cmd;
    sda_in  = sda;
    scl_in  = (s > 0) ? 1'b0 : 1'b1;
    go      = 1'b1;
    a       = ecnt + 1;
    ext     = (s > 0) ? s + 2 : 0;
    e.res   = cmd[1];
    if (e.res) begin
      e.fin  = a;
      e.fall = -1;
      e.rise = -1;
      e.db   = 1'b0;
      e.ack  = 1'b0;
      e.err  = 1'b1;
    end else begin
      e.fin  = a + 4 * Q + ext;
      e.fall = a;
      e.rise = a + 2 * Q;
      e.db   = sda;
      e.ack  = (cmd == 2'b01) && !sda;
      e.err  = tog;
    end
    sbq.push_back(e);
    wait_edge(a);
    command = 2'($urandom);
    if (drop_early) go = 1'b0;
    if (!e.res) begin
      if (s > 0) begin
        wait_edge(a + 2 * Q + s);
        scl_in = 1'b1;
      end
      if (tog) begin
        wait_edge(a + 3 * Q + ext - 2);
        sda_in = ~sda;
      end
    end
    guard = 0;
    while (!finish && guard < 200) begin
      step();
      guard++;
    end
    if (!finish) begin
      checks++;
      failures++;
      $display("FAIL finish_timeout actual=0 required=1 t=%0t", $time);
      sbq.delete();
      go = 1'b0;
      repeat (40) step();
      return;
    end
    if (rst_done) begin
      #2 rst = 1'b1;
      #1 chk_reset_values("rst_in_done");
      go = 1'b0;
      step();
      #2 rst = 1'b0;
      step();
      return;
    end
    if (go) begin
      repeat (hold) step();
      chk("finish_held", 32'(finish), 32'd1);
      go = 1'b0;
    end
    step();
    chk("release_finish", 32'(finish), 32'd0);
    chk("release_scl",    32'(scl),    32'd1);
  endtask

  // Abort a bit with an asynchronous reset placed off the clock edge
  task automatic reset_during(input int off, input string tag);
    int a;
    command = 2'b00;
    sda_in  = 1'b1;
    scl_in  = 1'b1;
    go      = 1'b1;
    a       = ecnt + 1;
    wait_edge(a + off);
    chk({tag, "_scl_before"}, 32'(scl), (off >= 2 * Q) ? 32'd1 : 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_values(tag);
    go = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rc;
    rst     = 1'b1;
    go      = 1'b0;
    command = 2'b00;
    scl_in  = 1'b1;
    sda_in  = 1'b1;
    repeat (3) step();
    chk_reset_values("reset");
    #2 rst = 1'b0;
    step();
    chk_reset_values("post_reset");

    run_bit(2'b00, 1'b1, 0,  1'b0, 1'b0, 0, 1'b0);
    run_bit(2'b01, 1'b0, 0,  1'b0, 1'b0, 1, 1'b0);
    run_bit(2'b01, 1'b1, 0,  1'b0, 1'b0, 0, 1'b0);
    run_bit(2'b00, 1'b1, 10, 1'b0, 1'b0, 2, 1'b0);
    run_bit(2'b00, 1'b0, 0,  1'b1, 1'b0, 0, 1'b0);
    run_bit(2'b00, 1'b1, 0,  1'b0, 1'b0, 0, 1'b0);
    run_bit(2'b10, 1'b0, 0,  1'b0, 1'b0, 2, 1'b0);
    run_bit(2'b11, 1'b1, 0,  1'b0, 1'b1, 0, 1'b0);
    run_bit(2'b00, 1'b0, 0,  1'b0, 1'b1, 0, 1'b0);
    reset_during(Q, "rst_low2");
    run_bit(2'b00, 1'b1, 0,  1'b0, 1'b0, 0, 1'b0);
    reset_during(2 * Q, "rst_high1");
    run_bit(2'b01, 1'b0, 3,  1'b0, 1'b0, 0, 1'b0);
    run_bit(2'b00, 1'b1, 0,  1'b1, 1'b0, 0, 1'b1);
    run_bit(2'b01, 1'b0, 0,  1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      run_bit(rc, 1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0,
              1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (5) step();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
